bp_be_late_wb_tracker: RTL



---
 rtl/bp_be_pkg.sv | 12 +
 rtl/bp_be_late_wb_ring_ptr.sv | 29 ++
 rtl/bp_be_late_wb_tracker.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bp_be_pkg.sv
// Shared back-end types for the late-writeback tracker.
package bp_be_pkg;

    localparam int bp_be_reg_addr_width_gp = 5;

    typedef struct packed {
        logic                               irf_w_v;
        logic                               frf_w_v;
        logic [bp_be_reg_addr_width_gp-1:0] rd_addr;
    } bp_be_late_wb_entry_s;

endpackage

// File: rtl/bp_be_late_wb_ring_ptr.sv
// Ring pointer with an extra wrap bit so full and empty can be told apart.
module bp_be_late_wb_ring_ptr
    import bp_be_pkg::*;
#(
    parameter int els_p = 4,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 inc_i,
    output logic [lg_els_lp-1:0] ptr_o,
    output logic                 wrap_o
);

    logic [lg_els_lp:0] cnt_r;

    // els_p is a power of two, so the natural carry into the top bit is the wrap toggle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r <= '0;
        end else if (inc_i) begin
            cnt_r <= cnt_r + {{lg_els_lp{1'b0}}, 1'b1};
        end
    end

    assign ptr_o  = cnt_r[lg_els_lp-1:0];
    assign wrap_o = cnt_r[lg_els_lp];

endmodule

// File: rtl/bp_be_late_wb_tracker.sv
// Non-blocking tracker of outstanding D$ load misses: in-order late writeback plus hazard query.
module bp_be_late_wb_tracker
    import bp_be_pkg::*;
#(
    parameter int els_p            = 4,
    parameter int reg_addr_width_p = bp_be_reg_addr_width_gp,
    parameter int dpath_width_p    = 66,
    parameter int num_query_p      = 3
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  flush_i,
    input  logic                                  alloc_v_i,
    input  logic                                  alloc_irf_w_v_i,
    input  logic                                  alloc_frf_w_v_i,
    input  logic [reg_addr_width_p-1:0]           alloc_rd_addr_i,
    output logic                                  ready_o,
    input  logic                                  fill_v_i,
    input  logic [dpath_width_p-1:0]              fill_data_i,
    output logic                                  iwb_v_o,
    output logic                                  fwb_v_o,
    output logic [reg_addr_width_p-1:0]           wb_rd_addr_o,
    output logic [dpath_width_p-1:0]              wb_data_o,
    input  logic [num_query_p*reg_addr_width_p-1:0] query_addr_i,
    input  logic [num_query_p-1:0]                query_fp_i,
    output logic [num_query_p-1:0]                hazard_o,
    output logic [$clog2(els_p):0]                count_o
);

    localparam int lg_els_lp = $clog2(els_p);

    logic [lg_els_lp-1:0]  head_ptr, tail_ptr;
    logic                  head_wrap, tail_wrap;
    logic                  empty, full, alloc_accept, fill_accept;
    bp_be_late_wb_entry_s  mem [els_p];
    bp_be_late_wb_entry_s  head_entry;
    logic [els_p-1:0]      entry_v;

    logic                        iwb_v_p1, fwb_v_p1;
    logic [reg_addr_width_p-1:0] wb_rd_addr_p1;
    logic [dpath_width_p-1:0]    wb_data_p1;

    assign empty   = (head_ptr == tail_ptr) && (head_wrap == tail_wrap);
    assign full    = (head_ptr == tail_ptr) && (head_wrap != tail_wrap);
    assign count_o = {tail_wrap, tail_ptr} - {head_wrap, head_ptr};
    assign ready_o = ~full;

    assign alloc_accept = alloc_v_i & ready_o & ~flush_i;
    assign fill_accept  = fill_v_i & ~empty;

    bp_be_late_wb_ring_ptr #(.els_p(els_p)) head_ptr_u (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc_i     (fill_accept),
        .ptr_o     (head_ptr),
        .wrap_o    (head_wrap)
    );

    bp_be_late_wb_ring_ptr #(.els_p(els_p)) tail_ptr_u (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc_i     (alloc_accept),
        .ptr_o     (tail_ptr),
        .wrap_o    (tail_wrap)
    );

    always_ff @(posedge clk_i) begin
        if (alloc_accept) begin
            mem[tail_ptr] <= '{irf_w_v: alloc_irf_w_v_i,
                               frf_w_v: alloc_frf_w_v_i,
                               rd_addr: alloc_rd_addr_i};
        end
    end

    assign head_entry = mem[head_ptr];

    // Stage p0 -> p1: fill data meets the head entry and is registered for writeback.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            iwb_v_p1      <= 1'b0;
            fwb_v_p1      <= 1'b0;
            wb_rd_addr_p1 <= '0;
            wb_data_p1    <= '0;
        end else begin
            iwb_v_p1 <= fill_accept & head_entry.irf_w_v & (head_entry.rd_addr != '0);
            fwb_v_p1 <= fill_accept & head_entry.frf_w_v;
            if (fill_accept) begin
                wb_rd_addr_p1 <= head_entry.rd_addr;
                wb_data_p1    <= fill_data_i;
            end
        end
    end

    assign iwb_v_o      = iwb_v_p1;
    assign fwb_v_o      = fwb_v_p1;
    assign wb_rd_addr_o = wb_rd_addr_p1;
    assign wb_data_o    = wb_data_p1;

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        entry_v = '0;
        for (int i = 0; i < els_p; i++) begin
            entry_v[i] = ({1'b0, lg_els_lp'(i) - head_ptr} < count_o);
        end
    end

    always_comb begin : hazard_blk
        logic [reg_addr_width_p-1:0] qa;
        logic                        qf;
        logic                        hit;
        hazard_o = '0;
        for (int q = 0; q < num_query_p; q++) begin
            qa  = query_addr_i[q*reg_addr_width_p +: reg_addr_width_p];
            qf  = query_fp_i[q];
            hit = (qf ? fwb_v_p1 : iwb_v_p1) && (wb_rd_addr_p1 == qa);
            for (int i = 0; i < els_p; i++) begin
                if (entry_v[i] && (mem[i].rd_addr == qa)
                    && (qf ? mem[i].frf_w_v : mem[i].irf_w_v)) begin
                    hit = 1'b1;
                end
            end
            hazard_o[q] = hit && (qf || (qa != '0));
        end
    end

    // Protocol violations are dropped by the accept logic; flag them in simulation.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(alloc_v_i && !ready_o))
                else $warning("protocol: alloc_v_i with ready_o low, request dropped");
            assert (!(fill_v_i && empty))
                else $warning("protocol: fill_v_i with no outstanding entry, request dropped");
        end
    end

endmodule
